// File: rtl/l2_arbiter.sv
// l2_arbiter
//   Shares the single L2 port between the L1 I-cache (line reads) and the
//   L1 D-cache (line reads and write-backs). One transaction is outstanding
//   at a time. When both sides request together, round-robin picks the side
//   that did not win last.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   icache_*            I-cache request (read/addr) and response (rdata/resp)
//   dcache_*            D-cache request (read/write/addr/wdata) and response
//   l2_read/l2_write    registered request to L2, held until l2_resp
//   l2_addr/l2_wdata    registered address / write line to L2
//   l2_rdata/l2_resp    line and one-cycle completion pulse from L2
//   i_grant_cnt         completed I-cache transactions (wraps)
//   d_grant_cnt         completed D-cache transactions (wraps)
module l2_arbiter #(
    parameter int W_ADDR = 32,
    parameter int W_LINE = 256,
    parameter int W_CNT  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache_read,
    input  logic [W_ADDR-1:0] icache_addr,
    output logic [W_LINE-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [W_ADDR-1:0] dcache_addr,
    input  logic [W_LINE-1:0] dcache_wdata,
    output logic [W_LINE-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [W_ADDR-1:0] l2_addr,
    output logic [W_LINE-1:0] l2_wdata,
    input  logic [W_LINE-1:0] l2_rdata,
    input  logic              l2_resp,
    output logic [W_CNT-1:0]  i_grant_cnt,
    output logic [W_CNT-1:0]  d_grant_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RECOVER = 2'd3
    } state_t;

    // last_grant: 0 = I won the previous arbitration, 1 = D won it.
    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    state_t state, state_nxt;
    logic   last_grant;
    logic   i_pend, d_pend;
    logic   grant_i, grant_d;

    assign i_pend = icache_read;
    assign d_pend = dcache_read | dcache_write;

    // I wins when alone, or on contention when D had the previous grant.
    assign grant_i = (state == IDLE) && i_pend && (!d_pend || last_grant == LAST_D);
    assign grant_d = (state == IDLE) && d_pend && !grant_i;

    // Both L1s see the L2 line; only the side with resp high consumes it.
    assign icache_rdata = l2_rdata;
    assign dcache_rdata = l2_rdata;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_i)      state_nxt = SERVE_I;
                else if (grant_d) state_nxt = SERVE_D;
            end
            SERVE_I: if (l2_resp) state_nxt = RECOVER;
            SERVE_D: if (l2_resp) state_nxt = RECOVER;
            // One quiet cycle so the L2 controller can settle back to idle.
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // Responses follow l2_resp combinationally so the L1 sees completion in
    // the same cycle; an l2_resp outside service is ignored.
    always_comb begin
        icache_resp = 1'b0;
        dcache_resp = 1'b0;
        case (state)
            SERVE_I: icache_resp = l2_resp;
            SERVE_D: dcache_resp = l2_resp;
            default: ;
        endcase
    end

    // ---------------- registered L2 request, arbitration history, counters ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l2_read     <= 1'b0;
            l2_write    <= 1'b0;
            l2_addr     <= '0;
            l2_wdata    <= '0;
            last_grant  <= LAST_D;
            i_grant_cnt <= '0;
            d_grant_cnt <= '0;
        end else begin
            if (grant_i) begin
                l2_addr    <= icache_addr;
                l2_read    <= 1'b1;
                l2_write   <= 1'b0;
                last_grant <= LAST_I;
            end else if (grant_d) begin
                l2_addr    <= dcache_addr;
                l2_wdata   <= dcache_wdata;
                // read+write together is treated as a write-back
                l2_write   <= dcache_write;
                l2_read    <= ~dcache_write;
                last_grant <= LAST_D;
            end

            if (icache_resp || dcache_resp) begin
                l2_read  <= 1'b0;
                l2_write <= 1'b0;
            end
            if (icache_resp) i_grant_cnt <= i_grant_cnt + W_CNT'(1);
            if (dcache_resp) d_grant_cnt <= d_grant_cnt + W_CNT'(1);
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter
//   Directed scenarios followed by a randomized run. A transaction-level
//   reference model tracks who owns the L2 port, the round-robin preference
//   and the expected L2 request, and every cycle is compared against it.
module tb_l2_arbiter;

    localparam int W_ADDR = 32;
    localparam int W_LINE = 256;
    localparam int W_CNT  = 4;
    localparam int CNT_MOD = 1 << W_CNT;

    logic              clk, rst_n;
    logic              icache_read;
    logic [W_ADDR-1:0] icache_addr;
    logic [W_LINE-1:0] icache_rdata;
    logic              icache_resp;
    logic              dcache_read, dcache_write;
    logic [W_ADDR-1:0] dcache_addr;
    logic [W_LINE-1:0] dcache_wdata;
    logic [W_LINE-1:0] dcache_rdata;
    logic              dcache_resp;
    logic              l2_read, l2_write;
    logic [W_ADDR-1:0] l2_addr;
    logic [W_LINE-1:0] l2_wdata;
    logic [W_LINE-1:0] l2_rdata;
    logic              l2_resp;
    logic [W_CNT-1:0]  i_grant_cnt, d_grant_cnt;

    l2_arbiter #(.W_ADDR(W_ADDR), .W_LINE(W_LINE), .W_CNT(W_CNT)) dut (
        .clk(clk), .rst_n(rst_n),
        .icache_read(icache_read), .icache_addr(icache_addr),
        .icache_rdata(icache_rdata), .icache_resp(icache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr),
        .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
        .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [W_LINE-1:0] got, input logic [W_LINE-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W_LINE-1:0] rand_line();
        logic [W_LINE-1:0] r;
        for (int k = 0; k < W_LINE / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- reference model ----------------
    // owner: 0 = port free, 1 = serving I, 2 = serving D
    int                m_owner;
    bit                m_cool;      // quiet cycle after a completion
    bit                m_prefer_i;  // who wins the next contention
    logic              m_rd, m_wr;
    logic [W_ADDR-1:0] m_addr;
    logic [W_LINE-1:0] m_wdata;
    int                m_icnt, m_dcnt;
    bit                m_iresp, m_dresp;

    task automatic model_reset();
        m_owner = 0; m_cool = 0; m_prefer_i = 1;
        m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
        m_icnt = 0; m_dcnt = 0; m_iresp = 0; m_dresp = 0;
    endtask

    // Compare this cycle's outputs (inputs already applied).
    task automatic half_check();
        @(negedge clk);
        m_iresp = (m_owner == 1) && l2_resp;
        m_dresp = (m_owner == 2) && l2_resp;
        chk("i_resp", icache_resp, m_iresp);
        chk("d_resp", dcache_resp, m_dresp);
        if (m_iresp) chk("i_rdata", icache_rdata, l2_rdata);
        if (m_dresp) chk("d_rdata", dcache_rdata, l2_rdata);
        chk("l2_read", l2_read, m_rd);
        chk("l2_write", l2_write, m_wr);
        chk("l2_addr", l2_addr, m_addr);
        chk("l2_wdata", l2_wdata, m_wdata);
        chk("i_cnt", i_grant_cnt, m_icnt);
        chk("d_cnt", d_grant_cnt, m_dcnt);
    endtask

    // Advance the model across the rising edge, then leave 1 time unit for driving.
    task automatic half_step();
        bit pi, pd;
        @(posedge clk);
        if (m_owner != 0) begin
            if (l2_resp) begin
                if (m_owner == 1) m_icnt = (m_icnt + 1) % CNT_MOD;
                else              m_dcnt = (m_dcnt + 1) % CNT_MOD;
                m_rd = 0; m_wr = 0; m_owner = 0; m_cool = 1;
            end
        end else if (m_cool) begin
            m_cool = 0;
        end else begin
            pi = icache_read;
            pd = dcache_read | dcache_write;
            if (pi && (!pd || m_prefer_i)) begin
                m_owner = 1; m_addr = icache_addr; m_rd = 1; m_wr = 0; m_prefer_i = 0;
            end else if (pd) begin
                m_owner = 2; m_addr = dcache_addr; m_wdata = dcache_wdata;
                m_wr = dcache_write; m_rd = !dcache_write; m_prefer_i = 1;
            end
        end
        #1;
    endtask

    task automatic cycle();
        half_check();
        half_step();
    endtask

    task automatic idle_inputs();
        icache_read = 0; dcache_read = 0; dcache_write = 0; l2_resp = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        icache_addr = '0; dcache_addr = '0; dcache_wdata = '0; l2_rdata = '0;
        model_reset();
        #1;
        chk("rst_l2_read", l2_read, 1'b0);
        chk("rst_l2_addr", l2_addr, '0);
        chk("rst_i_cnt", i_grant_cnt, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    // Random requesters: hold a request until its resp, occasionally abandon it.
    task automatic rand_drive();
        if (icache_read && m_iresp) icache_read = 0;
        else if (!icache_read && $urandom_range(3) == 0) begin
            icache_read = 1;
            icache_addr = $urandom & 32'hFFFF_FFE0;
        end else if (icache_read && $urandom_range(40) == 0) icache_read = 0;

        if ((dcache_read | dcache_write) && m_dresp) begin
            dcache_read = 0; dcache_write = 0;
        end else if (!(dcache_read | dcache_write) && $urandom_range(3) == 0) begin
            case ($urandom_range(2))
                0: begin dcache_read = 1; dcache_write = 0; end
                1: begin dcache_read = 0; dcache_write = 1; end
                default: begin dcache_read = 1; dcache_write = 1; end
            endcase
            dcache_addr  = $urandom & 32'hFFFF_FFE0;
            dcache_wdata = rand_line();
        end else if ((dcache_read | dcache_write) && $urandom_range(40) == 0) begin
            dcache_read = 0; dcache_write = 0;
        end

        l2_resp  = ($urandom_range(2) == 0);
        l2_rdata = rand_line();
    endtask

    initial begin
        logic [W_LINE-1:0] pat_a5, pat_p;
        bit order_q[$];
        int pulses;

        pat_a5 = {(W_LINE/8){8'hA5}};
        pat_p  = {(W_LINE/32){32'hDEAD_BEEF}};

        do_reset();

        // ---- single I read ----
        icache_read = 1; icache_addr = 32'h0000_1000;
        cycle();                                        // cycle 0: grant
        half_check();
        chk("t1_l2_read", l2_read, 1'b1);
        chk("t1_l2_addr", l2_addr, 32'h1000);
        half_step();
        cycle(); cycle();                               // cycles 2,3
        l2_resp = 1; l2_rdata = pat_a5;
        half_check();                                   // cycle 4
        chk("t1_i_resp", icache_resp, 1'b1);
        chk("t1_i_rdata", icache_rdata, pat_a5);
        half_step();
        icache_read = 0; l2_resp = 0;
        half_check();                                   // cycle 5
        chk("t1_l2_read_low", l2_read, 1'b0);
        chk("t1_i_cnt", i_grant_cnt, 4'd1);
        half_step();
        cycle();

        // ---- D write-back ----
        dcache_write = 1; dcache_addr = 32'h2000; dcache_wdata = pat_p;
        cycle();
        half_check();
        chk("t2_l2_write", l2_write, 1'b1);
        chk("t2_l2_wdata", l2_wdata, pat_p);
        chk("t2_l2_addr", l2_addr, 32'h2000);
        half_step();
        cycle();
        l2_resp = 1;
        half_check();
        chk("t2_d_resp", dcache_resp, 1'b1);
        chk("t2_i_resp", icache_resp, 1'b0);
        half_step();
        dcache_write = 0; l2_resp = 0;
        half_check();
        chk("t2_d_resp_once", dcache_resp, 1'b0);
        chk("t2_d_cnt", d_grant_cnt, 4'd1);
        half_step();

        // ---- continuous contention from reset; l2_resp held high throughout ----
        do_reset();
        icache_read = 1; dcache_read = 1; l2_resp = 1;
        for (int c = 0; c < 30 && order_q.size() < 4; c++) begin
            half_check();
            if (icache_resp) order_q.push_back(1'b0);
            if (dcache_resp) order_q.push_back(1'b1);
            half_step();
        end
        chk("t3_n_txn", order_q.size(), 4);
        for (int k = 0; k < order_q.size(); k++)
            chk($sformatf("t3_order%0d", k), order_q[k], (k % 2 == 1));
        chk("t3_i_cnt", i_grant_cnt, 4'd2);
        chk("t3_d_cnt", d_grant_cnt, 4'd2);
        idle_inputs();
        repeat (3) cycle();

        // ---- read+write together is a write; then reset during SERVE_D ----
        dcache_read = 1; dcache_write = 1; dcache_addr = 32'h3000; dcache_wdata = rand_line();
        cycle();
        half_check();
        chk("t4_l2_write", l2_write, 1'b1);
        chk("t4_l2_read", l2_read, 1'b0);
        half_step();
        half_check();
        l2_resp = 1;
        rst_n = 0;
        #1;
        chk("t5_l2_write", l2_write, 1'b0);
        chk("t5_d_resp", dcache_resp, 1'b0);
        chk("t5_d_cnt", d_grant_cnt, 4'd0);
        chk("t5_i_cnt", i_grant_cnt, 4'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1; l2_resp = 0;
        cycle();                                        // IDLE, grants D at this edge
        half_check();
        chk("t5_regrant", l2_write, 1'b1);
        half_step();

        // ---- counter wrap: 16 I transactions ----
        do_reset();
        icache_read = 1; icache_addr = 32'h4000;
        pulses = 0;
        for (int c = 0; c < 400 && pulses < 16; c++) begin
            l2_resp = ($urandom_range(1) == 1);
            half_check();
            if (icache_resp) pulses++;
            half_step();
        end
        chk("t6_pulses", pulses, 16);
        chk("t6_i_wrap", i_grant_cnt, 4'd0);
        idle_inputs();
        repeat (3) cycle();

        // ---- randomized traffic ----
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            half_check();
            half_step();
            rand_drive();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Two-port arbiter that shares the single L2 cache between the L1 instruction cache and the L1 data cache. It accepts line-granular (256-bit) read requests from the I-cache and read/write requests from the D-cache, and serialises them onto the L2 port one transaction at a time. Contention is resolved by round-robin priority. It sits between the two L1 caches and the L2 cache, which in turn fronts physical memory.

## Interface
Parameters:
- W_ADDR, 32, byte address width
- W_LINE, 256, cache line width in bits
- W_CNT, 32, grant-counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- icache_read  in  1  I-cache line read request, held until icache_resp
- icache_addr  in  W_ADDR  I-cache line address, stable while request held
- icache_rdata  out  W_LINE  line returned to I-cache
- icache_resp  out  1  one-cycle completion pulse to I-cache
- dcache_read  in  1  D-cache line read request, held until dcache_resp
- dcache_write  in  1  D-cache line write-back request, held until dcache_resp
- dcache_addr  in  W_ADDR  D-cache line address
- dcache_wdata  in  W_LINE  write-back line
- dcache_rdata  out  W_LINE  line returned to D-cache
- dcache_resp  out  1  one-cycle completion pulse to D-cache
- l2_read  out  1  read request to L2, registered
- l2_write  out  1  write request to L2, registered
- l2_addr  out  W_ADDR  address to L2, registered
- l2_wdata  out  W_LINE  write data to L2, registered
- l2_rdata  in  W_LINE  line from L2
- l2_resp  in  1  one-cycle L2 completion pulse
- i_grant_cnt  out  W_CNT  number of completed I-cache transactions
- d_grant_cnt  out  W_CNT  number of completed D-cache transactions

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D, RECOVER.
- IDLE: evaluate requests each cycle.
  - A pending I request is icache_read.
  - A pending D request is dcache_read|dcache_write.
  - If only one side is pending, grant that side.
  - If both are pending, grant the side opposite last_grant.
  - At the grant edge:
    - load l2_addr from the granted address;
    - load l2_wdata from dcache_wdata when D is granted;
    - set l2_read or l2_write;
    - update last_grant.
- D request with dcache_read and dcache_write both high: treat as a write (l2_write=1, l2_read=0).
- SERVE_I and SERVE_D:
  - hold all l2_* outputs constant until l2_resp.
  - On l2_resp: pulse the granted side's resp in the same cycle.
  - Increment that side's grant counter (wraps modulo 2^W_CNT).
  - Clear l2_read and l2_write at the edge.
  - Go to RECOVER.
- RECOVER: one cycle with no L2 request. It lets the L2 controller return to idle. Requests are ignored; go to IDLE.
- rdata paths:
  - icache_rdata = l2_rdata and dcache_rdata = l2_rdata, combinationally.
  - The value is valid only when the matching resp is high.
- The resp of the non-granted side is always 0. An l2_resp outside SERVE_* is ignored and increments nothing.
- A requester that drops its request mid-service is ignored. The transaction completes, and the resp still pulses.

## Timing
- Reset (async, rst_n=0):
  - state=IDLE and last_grant=D, so I wins the first contention;
  - l2_read=l2_write=0, l2_addr=0, l2_wdata=0;
  - both counters=0;
  - icache_resp=dcache_resp=0.
- Reset asserted mid-transaction: outputs clear immediately, with no resp. After release the FSM is in IDLE; the held request is re-arbitrated.
- Request seen in IDLE in cycle 0 → l2_read or l2_write high from cycle 1.
- l2_resp in cycle k → x_resp high in cycle k.
  - l2_* request low from cycle k+1 (RECOVER).
  - IDLE in cycle k+2.
  - Earliest next L2 request in cycle k+3.
- Minimum transaction occupancy is 3 cycles of L2 port time plus the L2 latency.
- Under continuous contention, grants strictly alternate I, D, I, D, …; neither side waits more than one other transaction.

## Test plan
- Single I read: icache_read=1 with addr 0x0000_1000 in cycle 0.
  - Expect l2_read=1 and l2_addr=0x1000 in cycle 1.
  - Drive l2_resp in cycle 4 with rdata=0xA5…A5.
  - Expect icache_resp=1 and icache_rdata=0xA5…A5 in cycle 4, l2_read=0 in cycle 5, i_grant_cnt=1.
- D write-back: dcache_write=1, addr 0x2000, wdata pattern P.
  - Expect l2_write=1, l2_wdata=P, l2_addr=0x2000 in the next cycle.
  - After l2_resp, expect dcache_resp=1 for exactly one cycle, icache_resp=0, d_grant_cnt=1.
- Simultaneous requests from reset: I and D both requesting continuously.
  - Expect grant order I, D, I, D over 4 transactions.
  - Counters end at 2 and 2.
- Illegal dcache_read=dcache_write=1 → l2_write=1 and l2_read=0.
- Reset mid-service: rst_n low in SERVE_D.
  - l2_write drops in the same cycle, counters are 0, no resp.
  - After release with D still requesting, D is re-granted one cycle later.
- Counter wrap: preload via W_CNT=4.
  - After 16 I transactions, i_grant_cnt=0.
